// File: rtl/reservation_station.sv
// Single-entry reservation station: captures one instruction, waits on CDB operands, issues to the FU, holds the result until retired.
// Latency: dispatch to done in 3 edges minimum (accept, issue handshake, fu_done); operands ready on the capturing edge.
// Backpressure: dispatch_ready only in IDLE; ISSUE holds until fu_issue_ready; DONE holds until retire.
module reservation_station #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 3,
  parameter int OP_WIDTH   = 4,
  parameter int STATION_ID = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dispatch_valid,
  output logic                  dispatch_ready,
  input  logic [OP_WIDTH-1:0]   dispatch_op,
  input  logic                  dispatch_src1_ready,
  input  logic [DATA_WIDTH-1:0] dispatch_src1_value,
  input  logic [TAG_WIDTH-1:0]  dispatch_src1_tag,
  input  logic                  dispatch_src2_ready,
  input  logic [DATA_WIDTH-1:0] dispatch_src2_value,
  input  logic [TAG_WIDTH-1:0]  dispatch_src2_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_rs_id,
  input  logic [DATA_WIDTH-1:0] cdb_result,
  output logic                  fu_issue_valid,
  input  logic                  fu_issue_ready,
  output logic [OP_WIDTH-1:0]   fu_op,
  output logic [DATA_WIDTH-1:0] fu_a,
  output logic [DATA_WIDTH-1:0] fu_b,
  input  logic                  fu_done,
  input  logic [DATA_WIDTH-1:0] fu_result,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  input  logic                  retire
);

  // The station's own tag must be representable on the CDB rs_id field.
  if (STATION_ID < 0 || STATION_ID >= (1 << TAG_WIDTH)) begin : g_bad_station_id
    $error("STATION_ID does not fit in TAG_WIDTH bits");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    ISSUE = 3'd2,
    EXEC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [OP_WIDTH-1:0]   op_q,       op_d;
  logic                  src1_rdy_q, src1_rdy_d;
  logic [DATA_WIDTH-1:0] src1_val_q, src1_val_d;
  logic [TAG_WIDTH-1:0]  src1_tag_q, src1_tag_d;
  logic                  src2_rdy_q, src2_rdy_d;
  logic [DATA_WIDTH-1:0] src2_val_q, src2_val_d;
  logic [TAG_WIDTH-1:0]  src2_tag_q, src2_tag_d;
  logic [DATA_WIDTH-1:0] result_q,   result_d;

  logic accept;
  logic disp_hit1, disp_hit2;
  logic wait_hit1, wait_hit2;

  // Dispatch handshake and CDB tag matches, both for the incoming instruction (bypass) and the held one.
  always_comb begin
    accept    = dispatch_valid && (state_q == IDLE);
    disp_hit1 = cdb_valid && (cdb_rs_id == dispatch_src1_tag);
    disp_hit2 = cdb_valid && (cdb_rs_id == dispatch_src2_tag);
    wait_hit1 = cdb_valid && !src1_rdy_q && (cdb_rs_id == src1_tag_q);
    wait_hit2 = cdb_valid && !src2_rdy_q && (cdb_rs_id == src2_tag_q);
  end

  // Operand/op/result next values: load on accept, capture from CDB only while waiting, result on fu_done in EXEC.
  always_comb begin
    op_d       = op_q;
    src1_rdy_d = src1_rdy_q;
    src1_val_d = src1_val_q;
    src1_tag_d = src1_tag_q;
    src2_rdy_d = src2_rdy_q;
    src2_val_d = src2_val_q;
    src2_tag_d = src2_tag_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d       = dispatch_op;
          src1_tag_d = dispatch_src1_tag;
          src2_tag_d = dispatch_src2_tag;
          src1_rdy_d = dispatch_src1_ready || disp_hit1;
          src2_rdy_d = dispatch_src2_ready || disp_hit2;
          src1_val_d = (!dispatch_src1_ready && disp_hit1) ? cdb_result : dispatch_src1_value;
          src2_val_d = (!dispatch_src2_ready && disp_hit2) ? cdb_result : dispatch_src2_value;
        end
      end
      WAIT: begin
        if (wait_hit1) begin
          src1_rdy_d = 1'b1;
          src1_val_d = cdb_result;
        end
        if (wait_hit2) begin
          src2_rdy_d = 1'b1;
          src2_val_d = cdb_result;
        end
      end
      EXEC: begin
        if (fu_done) begin
          result_d = fu_result;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; cleared by reset so an abandoned instruction leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      src1_rdy_q <= 1'b0;
      src1_val_q <= '0;
      src1_tag_q <= '0;
      src2_rdy_q <= 1'b0;
      src2_val_q <= '0;
      src2_tag_q <= '0;
      result_q   <= '0;
    end else begin
      op_q       <= op_d;
      src1_rdy_q <= src1_rdy_d;
      src1_val_q <= src1_val_d;
      src1_tag_q <= src1_tag_d;
      src2_rdy_q <= src2_rdy_d;
      src2_val_q <= src2_val_d;
      src2_tag_q <= src2_tag_d;
      result_q   <= result_d;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; readiness uses post-capture operand bits so WAIT->ISSUE costs no extra cycle.
  always_comb begin
    state_d        = state_q;
    dispatch_ready = 1'b0;
    fu_issue_valid = 1'b0;
    done           = 1'b0;
    case (state_q)
      IDLE: begin
        dispatch_ready = 1'b1;
        if (accept) begin
          state_d = (src1_rdy_d && src2_rdy_d) ? ISSUE : WAIT;
        end
      end
      WAIT: begin
        if (src1_rdy_d && src2_rdy_d) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        fu_issue_valid = 1'b1;
        if (fu_issue_ready) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (fu_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (retire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FU operands come straight from the held operand registers, so they stay at the last latched values outside ISSUE.
  assign fu_op  = op_q;
  assign fu_a   = src1_val_q;
  assign fu_b   = src2_val_q;
  assign result = result_q;

endmodule

// File: tb/tb_reservation_station.sv
// Testbench for reservation_station: directed scenarios then random traffic against an instruction-level model.
// Latency: checks every cycle, 1 time unit after the rising edge.
// Backpressure: random fu_issue_ready / fu_done / retire and occasional asynchronous resets.
module tb_reservation_station;

  localparam int DW = 64;
  localparam int TW = 3;
  localparam int OW = 4;

  localparam int PH_EMPTY     = 0;
  localparam int PH_WAITING   = 1;
  localparam int PH_OFFERING  = 2;
  localparam int PH_EXECUTING = 3;
  localparam int PH_FINISHED  = 4;

  logic          clk;
  logic          rst_n;
  logic          dispatch_valid;
  logic          dispatch_ready;
  logic [OW-1:0] dispatch_op;
  logic          dispatch_src1_ready;
  logic [DW-1:0] dispatch_src1_value;
  logic [TW-1:0] dispatch_src1_tag;
  logic          dispatch_src2_ready;
  logic [DW-1:0] dispatch_src2_value;
  logic [TW-1:0] dispatch_src2_tag;
  logic          cdb_valid;
  logic [TW-1:0] cdb_rs_id;
  logic [DW-1:0] cdb_result;
  logic          fu_issue_valid;
  logic          fu_issue_ready;
  logic [OW-1:0] fu_op;
  logic [DW-1:0] fu_a;
  logic [DW-1:0] fu_b;
  logic          fu_done;
  logic [DW-1:0] fu_result;
  logic          done;
  logic [DW-1:0] result;
  logic          retire;

  reservation_station #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .OP_WIDTH(OW), .STATION_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready), .dispatch_op(dispatch_op),
    .dispatch_src1_ready(dispatch_src1_ready), .dispatch_src1_value(dispatch_src1_value),
    .dispatch_src1_tag(dispatch_src1_tag),
    .dispatch_src2_ready(dispatch_src2_ready), .dispatch_src2_value(dispatch_src2_value),
    .dispatch_src2_tag(dispatch_src2_tag),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
    .fu_issue_valid(fu_issue_valid), .fu_issue_ready(fu_issue_ready), .fu_op(fu_op),
    .fu_a(fu_a), .fu_b(fu_b), .fu_done(fu_done), .fu_result(fu_result),
    .done(done), .result(result), .retire(retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: one instruction record and which phase of its life it is in.
  int            m_phase;
  logic          m_rdy [2];
  logic [DW-1:0] m_val [2];
  logic [TW-1:0] m_tag [2];
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_res;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_EMPTY;
    m_op    = '0;
    m_res   = '0;
    for (int n = 0; n < 2; n++) begin
      m_rdy[n] = 1'b0;
      m_val[n] = '0;
      m_tag[n] = '0;
    end
  endtask

  task automatic check_outputs();
    check_val("dispatch_ready", DW'(dispatch_ready), DW'(m_phase == PH_EMPTY));
    check_val("fu_issue_valid", DW'(fu_issue_valid), DW'(m_phase == PH_OFFERING));
    check_val("done", DW'(done), DW'(m_phase == PH_FINISHED));
    check_val("result", result, m_res);
    check_val("fu_a", fu_a, m_val[0]);
    check_val("fu_b", fu_b, m_val[1]);
    check_val("fu_op", DW'(fu_op), DW'(m_op));
  endtask

  // Advance the model with the inputs currently applied, take one clock edge, then compare.
  task automatic tick();
    logic          in_rdy [2];
    logic [DW-1:0] in_val [2];
    logic [TW-1:0] in_tag [2];
    logic          hit;
    in_rdy[0] = dispatch_src1_ready; in_val[0] = dispatch_src1_value; in_tag[0] = dispatch_src1_tag;
    in_rdy[1] = dispatch_src2_ready; in_val[1] = dispatch_src2_value; in_tag[1] = dispatch_src2_tag;
    case (m_phase)
      PH_EMPTY: if (dispatch_valid) begin
        m_op = dispatch_op;
        for (int n = 0; n < 2; n++) begin
          hit      = !in_rdy[n] && cdb_valid && (cdb_rs_id == in_tag[n]);
          m_rdy[n] = in_rdy[n] || hit;
          m_val[n] = hit ? cdb_result : in_val[n];
          m_tag[n] = in_tag[n];
        end
        m_phase = (m_rdy[0] && m_rdy[1]) ? PH_OFFERING : PH_WAITING;
      end
      PH_WAITING: begin
        for (int n = 0; n < 2; n++) begin
          if (!m_rdy[n] && cdb_valid && (cdb_rs_id == m_tag[n])) begin
            m_rdy[n] = 1'b1;
            m_val[n] = cdb_result;
          end
        end
        if (m_rdy[0] && m_rdy[1]) m_phase = PH_OFFERING;
      end
      PH_OFFERING:  if (fu_issue_ready) m_phase = PH_EXECUTING;
      PH_EXECUTING: if (fu_done) begin m_res = fu_result; m_phase = PH_FINISHED; end
      PH_FINISHED:  if (retire) m_phase = PH_EMPTY;
      default: ;
    endcase
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    dispatch_valid = 0; dispatch_op = '0;
    dispatch_src1_ready = 0; dispatch_src1_value = '0; dispatch_src1_tag = '0;
    dispatch_src2_ready = 0; dispatch_src2_value = '0; dispatch_src2_tag = '0;
    cdb_valid = 0; cdb_rs_id = '0; cdb_result = '0;
    fu_issue_ready = 0; fu_done = 0; fu_result = '0; retire = 0;
  endtask

  // Called 1 unit after an edge: assert reset mid-cycle, check outputs before any edge, release at the falling edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #1 rst_n = 1'b1;
  endtask

  task automatic drive_dispatch(input logic [OW-1:0] op,
                                input logic r1, input logic [DW-1:0] v1, input logic [TW-1:0] t1,
                                input logic r2, input logic [DW-1:0] v2, input logic [TW-1:0] t2);
    dispatch_valid = 1; dispatch_op = op;
    dispatch_src1_ready = r1; dispatch_src1_value = v1; dispatch_src1_tag = t1;
    dispatch_src2_ready = r2; dispatch_src2_value = v2; dispatch_src2_tag = t2;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    check_outputs();
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both operands ready: issue 5,7 then complete with 12 and retire.
    drive_dispatch(4'h3, 1, 64'd5, 3'd0, 1, 64'd7, 3'd0);
    tick();
    check_val("d1_issue_a", fu_a, 64'd5);
    check_val("d1_issue_b", fu_b, 64'd7);
    idle_inputs(); fu_issue_ready = 1;
    tick();
    idle_inputs(); fu_done = 1; fu_result = 64'd12;
    tick();
    check_val("d1_done", DW'(done), 64'd1);
    check_val("d1_result", result, 64'd12);
    idle_inputs(); retire = 1;
    tick();
    check_val("d1_back_ready", DW'(dispatch_ready), 64'd1);

    // Two waiting operands filled by separate broadcasts.
    drive_dispatch(4'h1, 0, 64'd0, 3'd2, 0, 64'd0, 3'd4);
    tick();
    idle_inputs(); cdb_valid = 1; cdb_rs_id = 3'd2; cdb_result = 64'hAA;
    tick();
    check_val("d2_still_wait", DW'(fu_issue_valid), 64'd0);
    cdb_rs_id = 3'd4; cdb_result = 64'hBB;
    tick();
    check_val("d2_issue", DW'(fu_issue_valid), 64'd1);
    check_val("d2_a", fu_a, 64'hAA);
    check_val("d2_b", fu_b, 64'hBB);
    idle_inputs();
    pulse_reset();

    // One broadcast feeds both operands.
    drive_dispatch(4'h2, 0, 64'd0, 3'd3, 0, 64'd0, 3'd3);
    tick();
    idle_inputs(); cdb_valid = 1; cdb_rs_id = 3'd3; cdb_result = 64'h10;
    tick();
    check_val("d3_a", fu_a, 64'h10);
    check_val("d3_b", fu_b, 64'h10);
    idle_inputs();
    pulse_reset();

    // Bypass in the accept cycle, then ISSUE stall with spurious retire/fu_done/CDB.
    drive_dispatch(4'h5, 0, 64'd0, 3'd1, 1, 64'd9, 3'd0);
    cdb_valid = 1; cdb_rs_id = 3'd1; cdb_result = 64'h55;
    tick();
    check_val("d4_issue", DW'(fu_issue_valid), 64'd1);
    check_val("d4_a", fu_a, 64'h55);
    check_val("d4_b", fu_b, 64'd9);
    idle_inputs(); retire = 1; fu_done = 1; fu_result = 64'hDEAD;
    cdb_valid = 1; cdb_rs_id = 3'd1; cdb_result = 64'h77;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("d5_hold_valid", DW'(fu_issue_valid), 64'd1);
      check_val("d5_hold_a", fu_a, 64'h55);
    end
    idle_inputs(); fu_issue_ready = 1;
    tick();
    idle_inputs();
    // Reset while executing returns to IDLE immediately.
    pulse_reset();
    check_val("d6_ready", DW'(dispatch_ready), 64'd1);
    check_val("d6_done", DW'(done), 64'd0);

    // Random traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      dispatch_valid      = ($urandom_range(0, 1) == 1);
      dispatch_op         = OW'($urandom);
      dispatch_src1_ready = ($urandom_range(0, 1) == 1);
      dispatch_src1_value = {$urandom, $urandom};
      dispatch_src1_tag   = TW'($urandom);
      dispatch_src2_ready = ($urandom_range(0, 1) == 1);
      dispatch_src2_value = {$urandom, $urandom};
      dispatch_src2_tag   = TW'($urandom);
      cdb_valid           = ($urandom_range(0, 4) < 2);
      cdb_rs_id           = TW'($urandom);
      cdb_result          = {$urandom, $urandom};
      fu_issue_ready      = ($urandom_range(0, 1) == 1);
      fu_done             = ($urandom_range(0, 4) < 2);
      fu_result           = {$urandom, $urandom};
      retire              = ($urandom_range(0, 4) < 2);
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
